// File: rtl/clock_display.sv
// Drives a 4-digit multiplexed 7-segment display from binary hour/min/sec.
// A shift-add-3 engine converts the selected field pair; a prescaler scans the digits.
module clock_display #(
    parameter int unsigned CLK_HZ     = 50000000,
    parameter int unsigned SCAN_HZ    = 1000,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] hour,
    input  logic [5:0] min,
    input  logic [5:0] sec,
    input  logic       dot,
    input  logic       mode,
    input  logic       blank_lead,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an,
    output logic       busy
);

    localparam int unsigned DIV = CLK_HZ / SCAN_HZ;
    localparam int unsigned PW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CONV_L,
        S_CONV_R,
        S_COMMIT
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    iter_q;
    logic          iter_last;
    logic [5:0]    bin_l_q, bin_r_q;
    logic [7:0]    bcd_l_q, bcd_r_q, adj_l, adj_r;
    logic          blank_lat_q, dot_lat_q;
    logic [3:0]    lt_q, lu_q, rt_q, ru_q;
    logic [3:0]    lt_d, lu_d, rt_d, ru_d;
    logic          disp_dot_q, disp_dot_d, disp_blank_q, disp_blank_d;
    logic [PW-1:0] presc_q;
    logic          tick;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    digit;
    logic [6:0]    seg_q, seg_act;
    logic [3:0]    an_q, an_act;
    logic          dp_q, dp_act;

    function automatic logic [7:0] add3(input logic [7:0] b);
        logic [7:0] r;
        r = b;
        if (b[3:0] >= 4'd5) r[3:0] = b[3:0] + 4'd3;
        if (b[7:4] >= 4'd5) r[7:4] = b[7:4] + 4'd3;
        return r;
    endfunction

    function automatic logic [6:0] seg_enc(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    assign iter_last = (iter_q == 3'd5);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = S_LOAD;
            S_LOAD:   state_d = S_CONV_L;
            S_CONV_L: if (iter_last) state_d = S_CONV_R;
            S_CONV_R: if (iter_last) state_d = S_COMMIT;
            S_COMMIT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != S_IDLE);
    end

    assign adj_l = add3(bcd_l_q);
    assign adj_r = add3(bcd_r_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            iter_q      <= '0;
            bin_l_q     <= '0;
            bin_r_q     <= '0;
            bcd_l_q     <= '0;
            bcd_r_q     <= '0;
            blank_lat_q <= 1'b0;
            dot_lat_q   <= 1'b0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    bin_l_q     <= mode ? min : {1'b0, hour};
                    bin_r_q     <= mode ? sec : min;
                    bcd_l_q     <= '0;
                    bcd_r_q     <= '0;
                    blank_lat_q <= blank_lead;
                    dot_lat_q   <= dot;
                    iter_q      <= '0;
                end
                S_CONV_L: begin
                    {bcd_l_q, bin_l_q} <= {adj_l[6:0], bin_l_q, 1'b0};
                    iter_q <= iter_last ? 3'd0 : iter_q + 3'd1;
                end
                S_CONV_R: begin
                    {bcd_r_q, bin_r_q} <= {adj_r[6:0], bin_r_q, 1'b0};
                    iter_q <= iter_last ? 3'd0 : iter_q + 3'd1;
                end
                default: ;
            endcase
        end
    end

    // Display next-state is exposed so a tick coinciding with COMMIT sees fresh digits.
    always_comb begin
        lt_d         = lt_q;
        lu_d         = lu_q;
        rt_d         = rt_q;
        ru_d         = ru_q;
        disp_dot_d   = disp_dot_q;
        disp_blank_d = disp_blank_q;
        if (state_q == S_COMMIT) begin
            lt_d         = bcd_l_q[7:4];
            lu_d         = bcd_l_q[3:0];
            rt_d         = bcd_r_q[7:4];
            ru_d         = bcd_r_q[3:0];
            disp_dot_d   = dot_lat_q;
            disp_blank_d = blank_lat_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lt_q         <= '0;
            lu_q         <= '0;
            rt_q         <= '0;
            ru_q         <= '0;
            disp_dot_q   <= 1'b0;
            disp_blank_q <= 1'b0;
        end else begin
            lt_q         <= lt_d;
            lu_q         <= lu_d;
            rt_q         <= rt_d;
            ru_q         <= ru_d;
            disp_dot_q   <= disp_dot_d;
            disp_blank_q <= disp_blank_d;
        end
    end

    always_comb begin
        tick  = (presc_q == PRESC_MAX);
        idx_d = idx_q + 2'd1;
        case (idx_d)
            2'd0:    digit = ru_d;
            2'd1:    digit = rt_d;
            2'd2:    digit = lu_d;
            default: digit = lt_d;
        endcase
        seg_act = (idx_d == 2'd3 && disp_blank_d && lt_d == 4'd0) ? 7'h00 : seg_enc(digit);
        an_act  = 4'b0001 << idx_d;
        dp_act  = (idx_d == 2'd2) && disp_dot_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= '0;
            idx_q   <= 2'd3;
            seg_q   <= {7{ACTIVE_LOW}};
            an_q    <= {4{ACTIVE_LOW}};
            dp_q    <= ACTIVE_LOW;
        end else begin
            presc_q <= tick ? '0 : presc_q + PW'(1);
            if (tick) begin
                idx_q <= idx_d;
                seg_q <= seg_act ^ {7{ACTIVE_LOW}};
                an_q  <= an_act ^ {4{ACTIVE_LOW}};
                dp_q  <= dp_act ^ ACTIVE_LOW;
            end
        end
    end

    assign seg = seg_q;
    assign an  = an_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_clock_display.sv
// Bench for clock_display: the display should show inputs sampled every 15 clocks
// with a fixed latency, scanned one digit every 4 clocks (DIV=4), active-low outputs.
module tb_clock_display;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] hour;
    logic [5:0] min, sec;
    logic       dot, mode, blank_lead;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       busy;

    int vectors     = 0;
    int miscompares = 0;
    int rel         = -1;

    int h_hour [4096];
    int h_min  [4096];
    int h_sec  [4096];
    int h_mode [4096];
    int h_dot  [4096];
    int h_blk  [4096];

    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    always #5 clk = ~clk;

    clock_display #(
        .CLK_HZ    (40),
        .SCAN_HZ   (10),
        .ACTIVE_LOW(1'b1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .hour      (hour),
        .min       (min),
        .sec       (sec),
        .dot       (dot),
        .mode      (mode),
        .blank_lead(blank_lead),
        .seg       (seg),
        .dp        (dp),
        .an        (an),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h rel=%0d", tag, obs, exp, rel);
        end
    endtask

    // Reference: after release edge 0, fields are sampled at edges 1+15n and become
    // visible from edge 14+15n; scan ticks land on edges 3+4m showing digit m mod 4.
    task automatic check_outputs();
        logic [6:0] es;
        logic [3:0] ea;
        logic       ed, eb, bl, dt;
        int         t, idx, s, lv, rv, dv;
        es = 7'h7F; ea = 4'hF; ed = 1'b1; eb = 1'b0;
        if (rel >= 0) begin
            eb = ((rel % 15) != 14);
            if (rel >= 3) begin
                t   = rel - ((rel - 3) % 4);
                idx = ((t - 3) / 4) % 4;
                if (t < 14) begin
                    lv = 0; rv = 0; bl = 1'b0; dt = 1'b0;
                end else begin
                    s  = 1 + 15 * ((t - 14) / 15);
                    lv = (h_mode[s] != 0) ? h_min[s] : h_hour[s];
                    rv = (h_mode[s] != 0) ? h_sec[s] : h_min[s];
                    bl = (h_blk[s] != 0);
                    dt = (h_dot[s] != 0);
                end
                case (idx)
                    0:       dv = rv % 10;
                    1:       dv = rv / 10;
                    2:       dv = lv % 10;
                    default: dv = lv / 10;
                endcase
                es = (idx == 3 && bl && (lv / 10) == 0) ? 7'h00 : seg_tab[dv];
                es = ~es;
                ea = ~(4'b0001 << idx);
                ed = ~(idx == 2 && dt);
            end
        end
        chk("seg", seg, es);
        chk("an", {3'b000, an}, {3'b000, ea});
        chk("dp", {6'b0, dp}, {6'b0, ed});
        chk("busy", {6'b0, busy}, {6'b0, eb});
    endtask

    task automatic cycle();
        int nxt;
        nxt = reset ? -1 : rel + 1;
        if (nxt >= 0 && nxt < 4096) begin
            h_hour[nxt] = hour;
            h_min[nxt]  = min;
            h_sec[nxt]  = sec;
            h_mode[nxt] = mode;
            h_dot[nxt]  = dot;
            h_blk[nxt]  = blank_lead;
        end
        @(posedge clk);
        rel = nxt;
        #1;
        check_outputs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wait_phase(input int ph);
        int guard;
        guard = 0;
        while ((rel % 15) != ph && guard < 30) begin
            cycle();
            guard++;
        end
        vectors++;
        assert (guard < 30) else begin
            miscompares++;
            $error("FAIL wait_phase observed=%0d expected=%0d", rel % 15, ph);
        end
    endtask

    initial begin
        reset = 1'b1; hour = 5'd13; min = 6'd47; sec = 6'd0;
        dot = 1'b1; mode = 1'b0; blank_lead = 1'b0;
        run(2);
        reset = 1'b0;
        run(45);

        mode = 1'b1; min = 6'd5; sec = 6'd59; blank_lead = 1'b1;
        for (int i = 0; i < 70; i++) begin
            if (i % 7 == 0) dot = ~dot;
            cycle();
        end

        mode = 1'b0; hour = 5'd13; min = 6'd47; blank_lead = 1'b0; dot = 1'b0;
        run(20);
        wait_phase(4);
        min = 6'd48;
        run(60);

        mode = 1'b1; min = 6'd63; sec = 6'd0;
        run(40);

        for (int b = 0; b < 20; b++) begin
            hour = 5'($urandom); min = 6'($urandom); sec = 6'($urandom);
            dot = 1'($urandom); mode = 1'($urandom); blank_lead = 1'($urandom);
            run(int'($urandom_range(1, 20)));
        end

        wait_phase(9);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        hour = 5'd9; min = 6'd30; mode = 1'b0; blank_lead = 1'b1; dot = 1'b1;
        run(64);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
